// File: rtl/fft_stage_stream.sv
// Streaming radix-2 butterfly stage: one butterfly per beat, 3-stage pipeline, stall-by-output-ready.
// Define FFT_STAGE_SAT_EN to saturate out-of-range results; otherwise they wrap (o_ovf flags both).
module fft_stage_stream #(
  parameter int unsigned P_REAL_BITS = 14,
  parameter int unsigned P_TW_BITS   = 16,
  parameter int unsigned P_LOG2N     = 5,
  parameter int unsigned P_STAGE     = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic                         i_first,
  input  logic [2*P_REAL_BITS-1:0]     i_a,
  input  logic [2*P_REAL_BITS-1:0]     i_b,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic                         o_last,
  output logic [2*P_REAL_BITS-1:0]     o_p,
  output logic [2*P_REAL_BITS-1:0]     o_m,
  input  logic                         i_tw_we,
  input  logic [P_LOG2N-2:0]           i_tw_addr,
  input  logic [2*P_TW_BITS-1:0]       i_tw_data,
  input  logic                         i_ovf_clr,
  output logic                         o_ovf
);

  localparam int unsigned W        = P_REAL_BITS;
  localparam int unsigned TW       = P_TW_BITS;
  localparam int unsigned KW       = P_LOG2N - 1;
  localparam int unsigned HALF_N   = 1 << KW;
  localparam int unsigned H        = 1 << P_STAGE;
  localparam int unsigned TW_SHIFT = P_LOG2N - 1 - P_STAGE;
  localparam int unsigned MW       = W + TW;
  localparam int unsigned PW       = MW + 1;
  localparam int unsigned W1       = W + 1;
  localparam int unsigned W2       = W + 2;
  localparam int unsigned FRAC     = TW - 2;
  localparam int unsigned RND      = 1 << (TW - 3);

  logic [2*TW-1:0] tw_mem [HALF_N];

  logic          en_c, acc_c;
  logic [KW-1:0] k, k_eff_c, tw_addr_c;

  logic          v1, last1;
  logic [2*W-1:0] a1, b1;
  logic [2*TW-1:0] w1;

  logic          v2, last2;
  logic [2*W-1:0] a2;
  logic signed [PW-1:0] pr2, pi2;

  logic signed [W-1:0]  b_re_c, b_im_c, a_re_c, a_im_c;
  logic signed [TW-1:0] w_re_c, w_im_c;
  logic signed [MW-1:0] m_rr_c, m_ii_c, m_ri_c, m_ir_c;
  logic signed [PW-1:0] prod_re_c, prod_im_c;
  logic signed [W1-1:0] bw_re_c, bw_im_c;
  logic [W:0]           p_re_c, p_im_c, m_re_c, m_im_c;
  logic                 oor_c;

  function automatic logic signed [W1-1:0] round_prod(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] t;
    t = x + $signed(PW'(RND));
    return W1'(t >>> FRAC);
  endfunction

  function automatic logic signed [W1-1:0] half_sum(input logic signed [W-1:0] a,
                                                    input logic signed [W1-1:0] y,
                                                    input logic sub);
    logic signed [W2-1:0] s;
    s = sub ? (W2'(a) - W2'(y)) : (W2'(a) + W2'(y));
    s = s + W2'(1);
    return W1'(s >>> 1);
  endfunction

  // Returns {out_of_range, reduced part}.
  function automatic logic [W:0] reduce(input logic signed [W1-1:0] x);
    logic         oor;
    logic [W-1:0] val;
    oor = x[W] ^ x[W-1];
`ifdef FFT_STAGE_SAT_EN
    val = oor ? {x[W], {(W-1){~x[W]}}} : x[W-1:0];
`else
    val = x[W-1:0];
`endif
    return {oor, val};
  endfunction

  assign en_c      = !o_valid || o_ready;
  assign i_ready   = en_c;
  assign acc_c     = i_valid && en_c;
  assign k_eff_c   = i_first ? '0 : k;
  assign tw_addr_c = (k_eff_c & KW'(H - 1)) << TW_SHIFT;

  // Twiddle RAM is deliberately unreset so coefficients survive a pipeline reset.
  always_ff @(posedge CLK) begin
    if (i_tw_we) tw_mem[i_tw_addr] <= i_tw_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       k <= '0;
    else if (acc_c) k <= k_eff_c + KW'(1);
  end

  // S1: operand and twiddle capture.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v1 <= 1'b0; last1 <= 1'b0; a1 <= '0; b1 <= '0; w1 <= '0;
    end else if (en_c) begin
      v1    <= i_valid;
      last1 <= i_valid && (k_eff_c == '1);
      a1    <= i_a;
      b1    <= i_b;
      w1    <= tw_mem[tw_addr_c];
    end
  end

  assign b_re_c    = b1[2*W-1:W];
  assign b_im_c    = b1[W-1:0];
  assign w_re_c    = w1[2*TW-1:TW];
  assign w_im_c    = w1[TW-1:0];
  assign m_rr_c    = MW'(b_re_c) * MW'(w_re_c);
  assign m_ii_c    = MW'(b_im_c) * MW'(w_im_c);
  assign m_ri_c    = MW'(b_re_c) * MW'(w_im_c);
  assign m_ir_c    = MW'(b_im_c) * MW'(w_re_c);
  assign prod_re_c = PW'(m_rr_c) - PW'(m_ii_c);
  assign prod_im_c = PW'(m_ri_c) + PW'(m_ir_c);

  // S2: full-precision b*W.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v2 <= 1'b0; last2 <= 1'b0; a2 <= '0; pr2 <= '0; pi2 <= '0;
    end else if (en_c) begin
      v2    <= v1;
      last2 <= last1;
      a2    <= a1;
      pr2   <= prod_re_c;
      pi2   <= prod_im_c;
    end
  end

  always_comb begin
    a_re_c  = a2[2*W-1:W];
    a_im_c  = a2[W-1:0];
    bw_re_c = round_prod(pr2);
    bw_im_c = round_prod(pi2);
    p_re_c  = reduce(half_sum(a_re_c, bw_re_c, 1'b0));
    p_im_c  = reduce(half_sum(a_im_c, bw_im_c, 1'b0));
    m_re_c  = reduce(half_sum(a_re_c, bw_re_c, 1'b1));
    m_im_c  = reduce(half_sum(a_im_c, bw_im_c, 1'b1));
    oor_c   = p_re_c[W] | p_im_c[W] | m_re_c[W] | m_im_c[W];
  end

  // S3: scaled sum/difference outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_valid <= 1'b0; o_last <= 1'b0; o_p <= '0; o_m <= '0;
    end else if (en_c) begin
      o_valid <= v2;
      o_last  <= last2;
      o_p     <= {p_re_c[W-1:0], p_im_c[W-1:0]};
      o_m     <= {m_re_c[W-1:0], m_im_c[W-1:0]};
    end
  end

  // Sticky overflow; a new overflow beats a coincident clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                     o_ovf <= 1'b0;
    else if (en_c && v2 && oor_c) o_ovf <= 1'b1;
    else if (i_ovf_clr)           o_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_fft_stage_stream.sv
// Self-checking bench for fft_stage_stream (N=32, stage 3) with a queue-based scoreboard.
module tb_fft_stage_stream;
  localparam int unsigned W  = 14;
  localparam int unsigned TW = 16;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [2*W-1:0] m;
    logic           last;
  } exp_t;

  logic clk, RST;
  logic i_valid, i_ready, i_first, o_valid, o_ready, o_last;
  logic [2*W-1:0] i_a, i_b, o_p, o_m;
  logic i_tw_we, i_ovf_clr, o_ovf;
  logic [3:0] i_tw_addr;
  logic [2*TW-1:0] i_tw_data;

  exp_t sb_q[$];
  logic [2*TW-1:0] tw_model [16];
  int k_model, checks, passes, out_cnt, last_cnt;
  logic out_seen, acc_seen;
  logic [2*W-1:0] out_p, out_m;
  logic [2*W-1:0] ba [16];
  logic [2*W-1:0] bb [16];

  fft_stage_stream #(.P_REAL_BITS(14), .P_TW_BITS(16), .P_LOG2N(5), .P_STAGE(3)) dut (
    .CLK(clk), .RST(RST), .i_valid(i_valid), .i_ready(i_ready), .i_first(i_first),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
    .o_p(o_p), .o_m(o_m), .i_tw_we(i_tw_we), .i_tw_addr(i_tw_addr), .i_tw_data(i_tw_data),
    .i_ovf_clr(i_ovf_clr), .o_ovf(o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] pk(input int re, input int im);
    return {W'(re), W'(im)};
  endfunction

  function automatic int half(input int s);
    return (s + 1) >>> 1;
  endfunction

  function automatic logic [W-1:0] red(input int h);
`ifdef FFT_STAGE_SAT_EN
    if (h > 8191) return W'(8191);
    if (h < -8192) return W'(-8192);
`endif
    return W'(h);
  endfunction

  // Integer reference: a +/- round(b*W), halved with rounding, then reduced.
  function automatic exp_t model(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                                 input logic [2*TW-1:0] w, input logic last);
    int ar, ai, br, bi, wr, wi, tr, ti;
    longint xr, xi;
    exp_t e;
    ar = int'($signed(a[2*W-1:W]));  ai = int'($signed(a[W-1:0]));
    br = int'($signed(b[2*W-1:W]));  bi = int'($signed(b[W-1:0]));
    wr = int'($signed(w[2*TW-1:TW])); wi = int'($signed(w[TW-1:0]));
    xr = longint'(br) * longint'(wr) - longint'(bi) * longint'(wi);
    xi = longint'(br) * longint'(wi) + longint'(bi) * longint'(wr);
    tr = int'((xr + 64'sd8192) >>> 14);
    ti = int'((xi + 64'sd8192) >>> 14);
    e.p = {red(half(ar + tr)), red(half(ai + ti))};
    e.m = {red(half(ar - tr)), red(half(ai - ti))};
    e.last = last;
    return e;
  endfunction

  function automatic logic [2*W-1:0] rnd_c();
    return pk(int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 8000)) - 4000);
  endfunction

  // One clock: settle, score any output beat, record any accepted beat, advance to next negedge.
  task automatic tick();
    exp_t e;
    int kk, addr;
    #1;
    out_seen = o_valid && o_ready;
    acc_seen = i_valid && i_ready;
    if (out_seen) begin
      out_p = o_p; out_m = o_m; out_cnt++;
      if (o_last) last_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL extra_beat: got p=%h m=%h, expected no output beat", o_p, o_m);
      end else begin
        e = sb_q.pop_front();
        if ({o_p, o_m, o_last} !== {e.p, e.m, e.last})
          $display("FAIL beat_%0d: got p=%h m=%h last=%b, expected p=%h m=%h last=%b",
                   out_cnt, o_p, o_m, o_last, e.p, e.m, e.last);
        else passes++;
      end
    end
    if (acc_seen) begin
      kk = i_first ? 0 : k_model;
      addr = (kk % 8) * 2;
      sb_q.push_back(model(i_a, i_b, tw_model[addr], kk == 15));
      k_model = (kk + 1) % 16;
    end
    @(negedge clk);
  endtask

  task automatic tw_write(input int addr, input logic [2*TW-1:0] data);
    i_tw_we = 1'b1; i_tw_addr = 4'(addr); i_tw_data = data;
    tick();
    tw_model[addr] = data;
    i_tw_we = 1'b0;
  endtask

  task automatic drain();
    i_valid = 1'b0; i_first = 1'b0; o_ready = 1'b1;
    for (int n = 0; n < 30 && sb_q.size() != 0; n++) tick();
  endtask

  task automatic test_reset();
    RST = 1'b0; i_valid = 0; i_first = 0; i_a = '0; i_b = '0; o_ready = 1'b1;
    i_tw_we = 0; i_tw_addr = '0; i_tw_data = '0; i_ovf_clr = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) $display("FAIL rst_valid: got %b, expected 0", o_valid); else passes++;
    checks++; if (o_last !== 1'b0) $display("FAIL rst_last: got %b, expected 0", o_last); else passes++;
    checks++; if (o_ovf !== 1'b0) $display("FAIL rst_ovf: got %b, expected 0", o_ovf); else passes++;
    checks++; if (o_p !== '0) $display("FAIL rst_p: got %h, expected 0", o_p); else passes++;
    checks++; if (o_m !== '0) $display("FAIL rst_m: got %h, expected 0", o_m); else passes++;
    @(negedge clk);
    RST = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) $display("FAIL rst_ready: got %b, expected 1", i_ready); else passes++;
    @(negedge clk);
  endtask

  // Single butterfly through twiddle address 0; checks latency and hand-derived results.
  task automatic test_directed(input string nm, input logic [2*TW-1:0] w,
                               input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                               input logic [2*W-1:0] ep, input logic [2*W-1:0] em);
    int lat;
    tw_write(0, w);
    i_valid = 1'b1; i_first = 1'b1; i_a = a; i_b = b; o_ready = 1'b1;
    tick();
    i_valid = 1'b0; i_first = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_seen && lat < 10);
    checks++; if (lat !== 3) $display("FAIL %s_latency: got %0d, expected 3", nm, lat); else passes++;
    checks++; if (out_p !== ep) $display("FAIL %s_p: got %h, expected %h", nm, out_p, ep); else passes++;
    checks++; if (out_m !== em) $display("FAIL %s_m: got %h, expected %h", nm, out_m, em); else passes++;
  endtask

  task automatic test_butterflies();
    int sat_p;
`ifdef FFT_STAGE_SAT_EN
    sat_p = 8191;
`else
    sat_p = -6496;
`endif
    test_directed("unity", {16'h4000, 16'h0000}, pk(100, 50), pk(20, -10), pk(60, 20), pk(40, 30));
    test_directed("minus_j", {16'h0000, 16'hC000}, pk(100, 50), pk(20, -10), pk(45, 15), pk(55, 35));
    checks++; if (o_ovf !== 1'b0) $display("FAIL ovf_idle: got %b, expected 0", o_ovf); else passes++;
    test_directed("overflow", {16'h2D41, 16'h2D41}, pk(8191, 0), pk(8191, -8191), pk(sat_p, 0), pk(-1696, 0));
    checks++; if (o_ovf !== 1'b1) $display("FAIL ovf_set: got %b, expected 1", o_ovf); else passes++;
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    checks++; if (o_ovf !== 1'b0) $display("FAIL ovf_clr: got %b, expected 0", o_ovf); else passes++;
  endtask

  task automatic test_frame();
    int j, base;
    for (int i = 0; i < 16; i++)
      tw_write(i, {TW'(i * 1500 - 11000), TW'(9000 - i * 1100)});
    for (int i = 0; i < 16; i++) begin ba[i] = rnd_c(); bb[i] = rnd_c(); end
    base = out_cnt; last_cnt = 0; j = 0;
    for (int c = 0; c < 100 && j < 16; c++) begin
      i_valid = 1'b1; i_first = (j == 0); i_a = ba[j]; i_b = bb[j]; o_ready = 1'b1;
      tick();
      if (acc_seen) j++;
    end
    drain();
    checks++; if (out_cnt - base !== 16) $display("FAIL frame_count: got %0d, expected 16", out_cnt - base); else passes++;
    checks++; if (last_cnt !== 1) $display("FAIL frame_last: got %0d, expected 1", last_cnt); else passes++;
    checks++; if (sb_q.size() !== 0) $display("FAIL frame_drain: got %0d pending, expected 0", sb_q.size()); else passes++;
  endtask

  task automatic test_back_to_back();
    int j, base;
    bit stalled;
    exp_t hd;
    for (int i = 0; i < 16; i++) begin ba[i] = rnd_c(); bb[i] = rnd_c(); end
    base = out_cnt; j = 0; stalled = 0;
    for (int c = 0; c < 300 && j < 16; c++) begin
      i_valid = 1'b1; i_first = (j == 0); i_a = ba[j]; i_b = bb[j];
      if (c == 8 && o_valid && sb_q.size() != 0) begin
        stalled = 1; o_ready = 1'b0; hd = sb_q[0];
        for (int s = 0; s < 2; s++) begin
          tick();
          checks++;
          if (i_ready !== 1'b0 || o_valid !== 1'b1 || o_p !== hd.p || o_m !== hd.m)
            $display("FAIL stall_hold_%0d: got rdy=%b vld=%b p=%h m=%h, expected rdy=0 vld=1 p=%h m=%h",
                     s, i_ready, o_valid, o_p, o_m, hd.p, hd.m);
          else passes++;
        end
        o_ready = 1'b1;
      end else begin
        o_ready = (c < 8) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
        tick();
        if (acc_seen) j++;
      end
    end
    drain();
    checks++; if (stalled !== 1'b1) $display("FAIL stall_reached: got %b, expected 1", stalled); else passes++;
    checks++; if (out_cnt - base !== 16) $display("FAIL b2b_count: got %0d, expected 16", out_cnt - base); else passes++;
    checks++; if (sb_q.size() !== 0) $display("FAIL b2b_drain: got %0d pending, expected 0", sb_q.size()); else passes++;
  endtask

  task automatic test_reset_midframe();
    int base;
    for (int j = 0; j < 6; j++) begin
      i_valid = 1'b1; i_first = (j == 0); i_a = rnd_c(); i_b = rnd_c(); o_ready = 1'b1;
      tick();
    end
    i_valid = 1'b0; i_first = 1'b0;
    RST = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) $display("FAIL midrst_valid: got %b, expected 0", o_valid); else passes++;
    checks++; if (o_p !== '0 || o_m !== '0) $display("FAIL midrst_data: got p=%h m=%h, expected 0", o_p, o_m); else passes++;
    sb_q.delete();
    k_model = 0;
    repeat (2) @(negedge clk);
    RST = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) $display("FAIL midrst_ready: got %b, expected 1", i_ready); else passes++;
    @(negedge clk);
    base = out_cnt;
    i_valid = 1'b1; i_first = 1'b0; i_a = pk(1234, -567); i_b = pk(-2000, 3000);
    tick();
    drain();
    checks++; if (out_cnt - base !== 1) $display("FAIL midrst_count: got %0d, expected 1", out_cnt - base); else passes++;
  endtask

  initial begin
    checks = 0; passes = 0; out_cnt = 0; last_cnt = 0; k_model = 0;
    out_seen = 0; acc_seen = 0; out_p = '0; out_m = '0;
    for (int i = 0; i < 16; i++) tw_model[i] = '0;
    test_reset();
    test_butterflies();
    test_frame();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fft_stage_stream.md
FFT_STAGE_STREAM -- requirements
Module: fft_stage_stream

Interface
REQ-001 Parameters SHALL be as follows:
- P_REAL_BITS, default 14: width of each real or imaginary part.
- P_TW_BITS, default 16: twiddle part width, P_TW_BITS-2 fraction bits, so 1.0 = 0x4000.
- P_LOG2N, default 5: FFT size N = 2^P_LOG2N.
- P_STAGE, default 3: stage index 0..P_LOG2N-1; span H = 2^P_STAGE.

REQ-002 Ports SHALL be as follows (complex words packed {re,im}, two's complement):
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input beat valid.
- i_ready  out  1  stage can accept a beat.
- i_first  in  1  beat is butterfly 0 of a frame.
- i_a  in  2*P_REAL_BITS  upper butterfly operand.
- i_b  in  2*P_REAL_BITS  lower butterfly operand.
- o_valid  out  1  output beat valid.
- o_ready  in  1  downstream accepts.
- o_last  out  1  beat is butterfly N/2-1.
- o_p  out  2*P_REAL_BITS  scaled a+b*W.
- o_m  out  2*P_REAL_BITS  scaled a-b*W.
- i_tw_we  in  1  twiddle write enable.
- i_tw_addr  in  P_LOG2N-1  twiddle address.
- i_tw_data  in  2*P_TW_BITS  twiddle W_N^addr.
- i_ovf_clr  in  1  clear sticky overflow.
- o_ovf  out  1  sticky overflow flag.

Function
REQ-003 Twiddle RAM SHALL hold N/2 entries; a write lands at the next edge; a same-cycle read of the written address SHALL return the old value.
REQ-004 Butterfly counter k SHALL advance on each accepted beat (i_valid & i_ready) and wrap from N/2-1 to 0.
REQ-005 An accepted beat with i_first=1 SHALL use k=0, and the counter SHALL become 1.
REQ-006 Twiddle address SHALL be (k mod H) * (N/(2H)).
REQ-007 The pipeline SHALL have 3 register stages:
- S1: capture a, b, twiddle, and last flag (k==N/2-1).
- S2: full-precision complex product b*W.
- S3: add/subtract, scale, saturate or wrap.
REQ-008 Latency SHALL be 3 enabled cycles from acceptance to o_valid.
REQ-009 Pipeline enable SHALL be en = !o_valid | o_ready, with i_ready = en; when en=0, all stages and outputs SHALL hold.
REQ-010 Bubbles SHALL propagate as valid=0; no beat is dropped or duplicated.
REQ-011 Product parts SHALL be computed at full width, then rounded: (x + 2^(P_TW_BITS-3)) >>> (P_TW_BITS-2), kept at P_REAL_BITS+1 bits.
REQ-012 Sum and difference SHALL be formed at P_REAL_BITS+2 bits, then (s+1) >>> 1, giving P_REAL_BITS+1 bits.
REQ-013 Each part SHALL be reduced to P_REAL_BITS bits per the Configuration section.
REQ-014 o_ovf SHALL set when any output part of a valid beat is out of range.
REQ-015 o_ovf SHALL clear on i_ovf_clr; when set and clear coincide, set wins.

Reset
REQ-016 While RST=0, the following SHALL hold:
- o_valid, o_last, o_ovf = 0.
- o_p, o_m = 0.
- all pipeline valids = 0.
- k = 0.
- i_ready = 1 after release.
REQ-017 Twiddle RAM SHALL NOT be reset; contents SHALL survive RST.
REQ-018 Reset mid-frame SHALL discard in-flight beats; the next accepted beat after reset uses k=0.

Configuration
REQ-019 With FFT_STAGE_SAT_EN defined, out-of-range parts SHALL clamp to +(2^(P_REAL_BITS-1)-1) or -2^(P_REAL_BITS-1).
REQ-020 Without FFT_STAGE_SAT_EN, parts SHALL wrap (MSB dropped); o_ovf SHALL still flag the condition.

Verification (P_REAL_BITS=14, P_TW_BITS=16, N=32, P_STAGE=3)
REQ-021 W=(0x4000,0), a=(100,50), b=(20,-10) -> 3 cycles later o_p=(60,20), o_m=(40,30).
REQ-022 W=(0,0xC000), same a and b -> o_p=(45,15), o_m=(55,35).
REQ-023 W=(0x2D41,0x2D41), a=(8191,0), b=(8191,-8191) -> results as follows:
- with SAT_EN: o_p=(8191,0).
- without SAT_EN: o_p=(-6496,0).
- both builds: o_m=(-1696,0), o_ovf=1.
- i_ovf_clr then clears o_ovf.
REQ-024 Distinct twiddles loaded at addresses 0..15; 16 beats with i_first on beat 0 -> beat 9 uses address 2, o_last only on beat 15.
REQ-025 o_ready held low 2 cycles while o_valid=1 -> o_p/o_m held, i_ready=0; 16 beats in -> exactly 16 out, in order.
REQ-026 RST asserted after beat 5 of a frame -> o_valid=0 immediately; post-reset beat uses twiddle address 0.
